// File: rtl/cnt_seq_pkg.sv
// Shared types and defaults for the counter command sequencer.
package cnt_seq_pkg;

  // Command opcodes carried on cmd_op.
  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_UP   = 2'b01,
    OP_DOWN = 2'b10,
    OP_HOLD = 2'b11
  } cmd_op_t;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_LOAD = 2'b01,
    S_RUN  = 2'b10,
    S_HOLD = 2'b11
  } seq_state_t;

  localparam int DEF_WIDTH = 8;

endpackage

// File: rtl/cnt_cmd_sequencer_ref.sv
// cnt_ref_model: shadow copy of the counter value. It follows the enables
// the sequencer drives and raises a sticky err when the counter's read-back
// value disagrees with the shadow copy.
module cnt_ref_model
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld_en,
  input  logic             en,
  input  logic             updwn,
  input  logic [WIDTH-1:0] datain,
  input  logic [WIDTH-1:0] dataout,
  output logic             err
);

  logic [WIDTH-1:0] exp_q, exp_d;
  logic             exp_vld_q, exp_vld_d;
  logic             prev_act_q, prev_act_d;
  logic             err_q, err_d;

  // Track the expected counter value and compare it in settled cycles.
  always_comb begin
    exp_d      = exp_q;
    exp_vld_d  = exp_vld_q;
    prev_act_d = ld_en | en;
    err_d      = err_q;
    if (ld_en) begin
      exp_d     = datain;
      exp_vld_d = 1'b1;
    end else if (en) begin
      if (updwn) begin
        exp_d = exp_q + WIDTH'(1);
      end else begin
        exp_d = exp_q - WIDTH'(1);
      end
    end else begin
      exp_d = exp_q;
    end
    // The cycle right after a load or step is skipped so the counter can settle.
    if (exp_vld_q && !prev_act_q && (dataout != exp_q)) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Shadow-model registers; err stays set until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      exp_q      <= '0;
      exp_vld_q  <= 1'b0;
      prev_act_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      exp_q      <= exp_d;
      exp_vld_q  <= exp_vld_d;
      prev_act_q <= prev_act_d;
      err_q      <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/cnt_cmd_sequencer.sv
// cnt_cmd_sequencer: takes LOAD/UP/DOWN/HOLD commands over valid/ready and
// drives the counter's ld_en/en/updwn/datain for exact cycle counts.
// Optional macro CNT_CHECK_EN adds the read-back checker (cnt_ref_model)
// that drives err. Without the macro, err is tied low and dataout is unused.
module cnt_cmd_sequencer
  import cnt_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic             ld_en,
  output logic             en,
  output logic             updwn,
  output logic [WIDTH-1:0] datain,
  input  logic [WIDTH-1:0] dataout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] remaining_q, remaining_d;
  logic             ld_en_q, ld_en_d;
  logic             en_q, en_d;
  logic             updwn_q, updwn_d;
  logic [WIDTH-1:0] datain_q, datain_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept_s;
  logic [LEN_W-1:0] arg_len_s;

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign accept_s  = cmd_valid && cmd_ready;
  assign arg_len_s = LEN_W'(cmd_arg);

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    ld_en_d     = 1'b0;
    en_d        = 1'b0;
    updwn_d     = updwn_q;
    datain_d    = datain_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          case (cmd_op_t'(cmd_op))
            OP_LOAD: begin
              state_d  = S_LOAD;
              ld_en_d  = 1'b1;
              datain_d = cmd_arg;
              busy_d   = 1'b1;
            end
            OP_UP, OP_DOWN: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                state_d     = S_RUN;
                remaining_d = arg_len_s - LEN_W'(1);
                en_d        = 1'b1;
                updwn_d     = (cmd_op_t'(cmd_op) == OP_UP);
                busy_d      = 1'b1;
              end
            end
            OP_HOLD: begin
              if (cmd_arg == '0) begin
                done_d = 1'b1;
              end else begin
                state_d     = S_HOLD;
                remaining_d = arg_len_s - LEN_W'(1);
                busy_d      = 1'b1;
              end
            end
            default: begin
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
      S_RUN, S_HOLD: begin
        if (remaining_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          remaining_d = remaining_q - LEN_W'(1);
          en_d        = (state_q == S_RUN);
          busy_d      = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset aborts any command in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      remaining_q <= '0;
      ld_en_q     <= 1'b0;
      en_q        <= 1'b0;
      updwn_q     <= 1'b0;
      datain_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      ld_en_q     <= ld_en_d;
      en_q        <= en_d;
      updwn_q     <= updwn_d;
      datain_q    <= datain_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ld_en  = ld_en_q;
  assign en     = en_q;
  assign updwn  = updwn_q;
  assign datain = datain_q;
  assign busy   = busy_q;
  assign done   = done_q;

`ifdef CNT_CHECK_EN
  cnt_ref_model #(.WIDTH(WIDTH)) u_ref (
    .clk     (clk),
    .rst     (rst),
    .ld_en   (ld_en_q),
    .en      (en_q),
    .updwn   (updwn_q),
    .datain  (datain_q),
    .dataout (dataout),
    .err     (err)
  );
`else
  logic unused_dataout_s;
  assign unused_dataout_s = ^dataout;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cnt_cmd_sequencer.sv
// Bench for cnt_cmd_sequencer: a behavioural counter closes the loop, and a
// scoreboard queue holds one expected output vector per cycle for every
// accepted command.
module tb_cnt_cmd_sequencer;
  import cnt_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_arg;
  logic       ld_en, en, updwn, busy, done, err;
  logic [7:0] datain, dataout;

  logic [7:0] cnt;
  logic       corrupt = 1'b0;
  logic       mon_off = 1'b1;
  int         n_cmp = 0;
  int         n_bad = 0;

  logic [22:0] exp_q[$];
  logic        m_updwn = 1'b0;
  logic [7:0]  m_datain = 8'h00;
  logic [7:0]  m_cnt = 8'h00;
  logic [22:0] got_s;

  cnt_cmd_sequencer #(.WIDTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .ld_en(ld_en), .en(en),
    .updwn(updwn), .datain(datain), .dataout(dataout), .busy(busy),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural 8-bit up/down/load counter driven by the sequencer.
  always @(posedge clk) begin
    if (rst) cnt <= 8'h00;
    else if (ld_en) cnt <= datain;
    else if (en) cnt <= updwn ? cnt + 8'h01 : cnt - 8'h01;
  end
  assign dataout = corrupt ? (cnt ^ 8'h01) : cnt;

  assign got_s = {cmd_ready, ld_en, en, updwn, datain, busy, done, dataout, err};

  task automatic check_val(input string tag, input logic [22:0] got, input logic [22:0] expv);
    n_cmp++;
    if (got !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (rdy,ld,en,ud,din,busy,done,dout,err) at %0t",
               tag, got, expv, $time);
    end
  endtask

  function automatic logic [22:0] mk(input logic rdy, input logic ld, input logic e,
                                     input logic ud, input logic [7:0] din,
                                     input logic bsy, input logic dn,
                                     input logic [7:0] dout);
    return {rdy, ld, e, ud, din, bsy, dn, dout, 1'b0};
  endfunction

  // Scoreboard: push the expected per-cycle outputs of an accepted command.
  task automatic push_cmd(input logic [1:0] op, input logic [7:0] arg);
    logic run;
    if (op == OP_LOAD) begin
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, m_updwn, arg, 1'b1, 1'b0, m_cnt));
      m_cnt    = arg;
      m_datain = arg;
    end else begin
      run = (op == OP_UP) || (op == OP_DOWN);
      if (arg != 8'h00) begin
        if (run) m_updwn = (op == OP_UP);
        for (int i = 0; i < int'(arg); i++) begin
          exp_q.push_back(mk(1'b0, 1'b0, run, m_updwn, m_datain, 1'b1, 1'b0, m_cnt));
          if (run) m_cnt = m_updwn ? m_cnt + 8'h01 : m_cnt - 8'h01;
        end
      end
    end
    exp_q.push_back(mk(1'b1, 1'b0, 1'b0, m_updwn, m_datain, 1'b0, 1'b1, m_cnt));
  endtask

  // Drive a command and hold cmd_valid until it is accepted (bounded wait).
  task automatic send(input logic [1:0] op, input logic [7:0] arg);
    int n;
    @(negedge clk);
    cmd_op    = op;
    cmd_arg   = arg;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      check_val("accept_timeout", {22'h0, cmd_ready}, 23'h1);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      push_cmd(op, arg);
    end
  endtask

  task automatic idle(input int n);
    #1 cmd_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Per-cycle monitor: compare against the queue head or the idle vector.
  always @(negedge clk) begin
    logic [22:0] e;
    if (!mon_off) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = mk(1'b1, 1'b0, 1'b0, m_updwn, m_datain, 1'b0, 1'b0, m_cnt);
      check_val("cycle", got_s, e);
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = OP_LOAD; cmd_arg = 8'h55;
    // Reset with a pending command: nothing may be accepted.
    repeat (2) begin
      @(negedge clk);
      check_val("reset_outs", got_s, 23'h0);
    end
    rst = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;
    check_val("release_ready", got_s, mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00));
    mon_off = 1'b0;

    send(OP_LOAD, 8'h64); idle(2);
    send(OP_DOWN, 8'd5);  idle(2);
    send(OP_LOAD, 8'hFE); idle(1);
    send(OP_UP, 8'd3);    idle(1);
    send(OP_UP, 8'd0);    idle(2);
    send(OP_HOLD, 8'd4);
    send(OP_UP, 8'd2);    idle(4);

    // Reset pulse in the middle of UP 10, after three steps.
    send(OP_UP, 8'd10);
    repeat (3) @(posedge clk);
    #1 mon_off = 1'b1; rst = 1'b1; cmd_valid = 1'b0;
    exp_q.delete();
    @(posedge clk); #1;
    check_val("abort_outs", got_s, 23'h0);
    rst = 1'b0; m_cnt = 8'h00; m_updwn = 1'b0; m_datain = 8'h00;
    mon_off = 1'b0;
    repeat (3) @(posedge clk);
    send(OP_DOWN, 8'd2); idle(3);

`ifdef CNT_CHECK_EN
    send(OP_LOAD, 8'h10); idle(3);
    #1 mon_off = 1'b1; corrupt = 1'b1;
    repeat (3) @(negedge clk);
    check_val("err_set", {22'h0, err}, 23'h1);
    corrupt = 1'b0;
    repeat (3) @(negedge clk);
    check_val("err_sticky", {22'h0, err}, 23'h1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    check_val("err_clear", {22'h0, err}, 23'h0);
    rst = 1'b0;
`endif

    @(posedge clk); #1 mon_off = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
